// File: rtl/zbuf_addr_gen.sv
// Z-buffer byte address generator: fp16 (x,y) -> linear or 8x8-tiled depth sample address.
// Input register, then three compute stages (convert, index, base add) with elastic handshakes.
module zbuf_addr_gen #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned XRES      = 640,
    parameter int unsigned YRES      = 480,
    parameter int unsigned PITCH     = 640,
    parameter int unsigned BPP_LOG2  = 2,
    parameter int unsigned TILE_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nd,
    output logic              us_rfd,
    input  logic [15:0]       fp_x,
    input  logic [15:0]       fp_y,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              tiled,
    input  logic              ds_rfd,
    output logic              rdy,
    output logic [ADDR_W-1:0] zbuff_addr,
    output logic              oob
);

    // Clamped coordinates are 16 bits; the index needs 16 + log2(PITCH) bits plus carry margin.
    localparam int unsigned IDX_W = 18 + $clog2(PITCH);
    localparam int unsigned SUM_W = (IDX_W + BPP_LOG2 > ADDR_W) ? IDX_W + BPP_LOG2 : ADDR_W;
    localparam logic [IDX_W-1:0] TILE_MASK = IDX_W'((1 << TILE_LOG2) - 1);

    // Returns {invalid, floor(value)}; negative, Inf and NaN inputs map to 0 with invalid set.
    function automatic logic [16:0] fp16_to_int(input logic [15:0] h);
        logic [4:0]  e;
        logic [15:0] sig;
        logic [15:0] val;
        logic        bad;
        e   = h[14:10];
        sig = {5'd0, 1'b1, h[9:0]};
        val = '0;
        bad = 1'b0;
        if (e == 5'd31) begin
            bad = 1'b1;
        end else if (h[15] && (h[14:0] != 15'd0)) begin
            bad = 1'b1;
        end else if (e >= 5'd15) begin
            if (e <= 5'd25) val = sig >> (5'd25 - e);
            else            val = sig << (e - 5'd25);
        end
        return {bad, val};
    endfunction

    function automatic logic [16:0] clamp(input logic [15:0] v, input int unsigned lim);
        if (32'(v) >= lim) return {1'b1, 16'(lim - 32'd1)};
        return {1'b0, v};
    endfunction

    // Input register
    logic              v1_q;
    logic [15:0]       fx1_q, fy1_q;
    logic [ADDR_W-1:0] base1_q;
    logic              tiled1_q;
    // Converted coordinates
    logic              v2_q;
    logic [15:0]       x2_q, y2_q;
    logic              oob2_q;
    logic [ADDR_W-1:0] base2_q;
    logic              tiled2_q;
    // Sample index
    logic              v3_q;
    logic [IDX_W-1:0]  idx3_q;
    logic              oob3_q;
    logic [ADDR_W-1:0] base3_q;
    // Output register
    logic              rdy_q;
    logic [ADDR_W-1:0] addr_q;
    logic              oob_q;

    logic adv1, adv2, adv3, accept;

    always_comb begin
        adv3   = v3_q & (~rdy_q | ds_rfd);
        adv2   = v2_q & (~v3_q | adv3);
        adv1   = v1_q & (~v2_q | adv2);
        us_rfd = ~v1_q | adv1;
        accept = nd & us_rfd;
    end

    logic [16:0]       cx, cy, lx, ly;
    logic              oob2_d;
    always_comb begin
        cx     = fp16_to_int(fx1_q);
        cy     = fp16_to_int(fy1_q);
        lx     = clamp(cx[15:0], XRES);
        ly     = clamp(cy[15:0], YRES);
        oob2_d = cx[16] | cy[16] | lx[16] | ly[16];
    end

    logic [IDX_W-1:0] xw, yw, lin_idx, tile_lin, tile_idx, idx3_d;
    always_comb begin
        xw       = IDX_W'(x2_q);
        yw       = IDX_W'(y2_q);
        lin_idx  = yw * IDX_W'(PITCH) + xw;
        tile_lin = (yw >> TILE_LOG2) * IDX_W'(PITCH >> TILE_LOG2) + (xw >> TILE_LOG2);
        tile_idx = (tile_lin << (2 * TILE_LOG2)) | ((yw & TILE_MASK) << TILE_LOG2)
                 | (xw & TILE_MASK);
        idx3_d   = tiled2_q ? tile_idx : lin_idx;
    end

    logic [ADDR_W-1:0] addr_d;
    always_comb begin
        addr_d = ADDR_W'(SUM_W'(base3_q) + (SUM_W'(idx3_q) << BPP_LOG2));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            fx1_q    <= '0;
            fy1_q    <= '0;
            base1_q  <= '0;
            tiled1_q <= 1'b0;
            v2_q     <= 1'b0;
            x2_q     <= '0;
            y2_q     <= '0;
            oob2_q   <= 1'b0;
            base2_q  <= '0;
            tiled2_q <= 1'b0;
            v3_q     <= 1'b0;
            idx3_q   <= '0;
            oob3_q   <= 1'b0;
            base3_q  <= '0;
            rdy_q    <= 1'b0;
            addr_q   <= '0;
            oob_q    <= 1'b0;
        end else begin
            v1_q  <= accept | (v1_q & ~adv1);
            v2_q  <= adv1 | (v2_q & ~adv2);
            v3_q  <= adv2 | (v3_q & ~adv3);
            rdy_q <= adv3 | (rdy_q & ~ds_rfd);
            if (accept) begin
                fx1_q    <= fp_x;
                fy1_q    <= fp_y;
                base1_q  <= base_addr;
                tiled1_q <= tiled;
            end
            if (adv1) begin
                x2_q     <= lx[15:0];
                y2_q     <= ly[15:0];
                oob2_q   <= oob2_d;
                base2_q  <= base1_q;
                tiled2_q <= tiled1_q;
            end
            if (adv2) begin
                idx3_q  <= idx3_d;
                oob3_q  <= oob2_q;
                base3_q <= base2_q;
            end
            if (adv3) begin
                addr_q <= addr_d;
                oob_q  <= oob3_q;
            end
        end
    end

    assign rdy        = rdy_q;
    assign zbuff_addr = addr_q;
    assign oob        = oob_q;

endmodule

// File: tb/tb_zbuf_addr_gen.sv
// Directed bench for zbuf_addr_gen: layouts, bounds, latency, stall/backpressure and reset.
module tb_zbuf_addr_gen;

    logic        clk, rst, nd, us_rfd, tiled, ds_rfd, rdy, oob;
    logic [15:0] fp_x, fp_y;
    logic [31:0] base_addr, zbuff_addr;
    int checks = 0;
    int errors = 0;

    zbuf_addr_gen dut (
        .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd), .fp_x(fp_x), .fp_y(fp_y),
        .base_addr(base_addr), .tiled(tiled), .ds_rfd(ds_rfd), .rdy(rdy),
        .zbuff_addr(zbuff_addr), .oob(oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one fragment, waits (bounded) for its result; lat = edges from accept to rdy.
    task automatic drive_one(input logic [15:0] fx, input logic [15:0] fy, input logic [31:0] b,
                             input logic t, output logic [31:0] a, output logic o,
                             output int lat, output logic took);
        @(negedge clk);
        fp_x = fx; fp_y = fy; base_addr = b; tiled = t; nd = 1'b1;
        took = us_rfd;
        @(posedge clk);
        @(negedge clk);
        nd = 1'b0;
        lat = 0;
        while (!rdy && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        a = zbuff_addr; o = oob;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
        checks++;
        if (zbuff_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr got %h want 00000000", zbuff_addr);
        end
        checks++; if (oob !== 1'b0) begin errors++; $display("FAIL reset_oob got %b want 0", oob); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (us_rfd !== 1'b1) begin errors++; $display("FAIL reset_us_rfd got %b want 1", us_rfd); end
    endtask

    task automatic test_linear();
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        logic [31:0] ea [3];
        logic [31:0] a;
        logic o, took;
        int lat;
        xs = '{16'h0000, 16'h3C00, 16'h3800};
        ys = '{16'h0000, 16'h3C00, 16'h3A66};
        ea = '{32'h1000_0000, 32'h1000_0A04, 32'h1000_0000};
        ds_rfd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_one(xs[i], ys[i], 32'h1000_0000, 1'b0, a, o, lat, took);
            checks++; if (!took) begin errors++; $display("FAIL lin%0d_accept got 0 want 1", i); end
            checks++; if (lat != 3) begin errors++; $display("FAIL lin%0d_latency got %0d want 3", i, lat); end
            checks++; if (a !== ea[i]) begin errors++; $display("FAIL lin%0d_addr got %h want %h", i, a, ea[i]); end
            checks++; if (o !== 1'b0) begin errors++; $display("FAIL lin%0d_oob got %b want 0", i, o); end
        end
    endtask

    task automatic test_tiled();
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        logic [31:0] ea [3];
        logic [31:0] a;
        logic o, took;
        int lat;
        xs = '{16'h4880, 16'h0000, 16'h4700};
        ys = '{16'h4900, 16'h0000, 16'h4800};
        ea = '{32'h1000_5144, 32'h1000_0000, 32'h1000_501C};
        for (int i = 0; i < 3; i++) begin
            drive_one(xs[i], ys[i], 32'h1000_0000, 1'b1, a, o, lat, took);
            checks++; if (a !== ea[i]) begin errors++; $display("FAIL tile%0d_addr got %h want %h", i, a, ea[i]); end
            checks++; if (o !== 1'b0) begin errors++; $display("FAIL tile%0d_oob got %b want 0", i, o); end
        end
    endtask

    task automatic test_oob();
        logic [15:0] xs [9];
        logic [15:0] ys [9];
        logic [31:0] bs [9];
        logic [31:0] ea [9];
        logic        eo [9];
        logic [31:0] a;
        logic o, took;
        int lat;
        xs = '{16'h6100, 16'hBC00, 16'h7E00, 16'h7C00, 16'h60FE,
               16'h0000, 16'h8000, 16'h7BFF, 16'h4800};
        ys = '{16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h5F7C,
               16'h5F80, 16'h8000, 16'h0000, 16'h0000};
        bs = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000,
               32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'hFFFF_FFF0};
        ea = '{32'h1000_09FC, 32'h1000_0000, 32'h1000_0000, 32'h1000_0A00, 32'h1012_BFFC,
               32'h1012_B600, 32'h1000_0000, 32'h1000_09FC, 32'h0000_0010};
        eo = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive_one(xs[i], ys[i], bs[i], 1'b0, a, o, lat, took);
            checks++; if (a !== ea[i]) begin errors++; $display("FAIL oob%0d_addr got %h want %h", i, a, ea[i]); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL oob%0d_flag got %b want %b", i, o, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        logic        ts [4];
        logic [31:0] ea [4];
        logic        eo [4];
        int k, first, last;
        xs = '{16'h3C00, 16'h0000, 16'h4880, 16'h6100};
        ys = '{16'h3C00, 16'h0000, 16'h4900, 16'h0000};
        ts = '{1'b0, 1'b0, 1'b1, 1'b0};
        ea = '{32'h1000_0A04, 32'h1000_0000, 32'h1000_5144, 32'h1000_09FC};
        eo = '{1'b0, 1'b0, 1'b0, 1'b1};
        k = 0; first = -1; last = -1;
        ds_rfd = 1'b1; base_addr = 32'h1000_0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdy) begin
                if (k < 4) begin
                    checks++;
                    if (zbuff_addr !== ea[k] || oob !== eo[k]) begin
                        errors++;
                        $display("FAIL b2b%0d got %h/%b want %h/%b", k, zbuff_addr, oob, ea[k], eo[k]);
                    end
                end
                if (first < 0) first = c;
                last = c;
                k++;
            end
            if (c < 4) begin
                checks++; if (us_rfd !== 1'b1) begin errors++; $display("FAIL b2b_us_rfd%0d got %b want 1", c, us_rfd); end
                fp_x = xs[c]; fp_y = ys[c]; tiled = ts[c]; nd = 1'b1;
            end else begin
                nd = 1'b0;
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", k); end
        checks++; if (first != 4) begin errors++; $display("FAIL b2b_first_cycle got %0d want 4", first); end
        checks++; if (last != 7) begin errors++; $display("FAIL b2b_last_cycle got %0d want 7", last); end
    endtask

    task automatic test_stall();
        logic [15:0] xs [5];
        logic [15:0] ys [5];
        logic        ts [5];
        logic [31:0] ea [4];
        logic        eo [4];
        int n, acc, idx, k, first, last;
        xs = '{16'h3C00, 16'h4880, 16'h4800, 16'h6100, 16'h0000};
        ys = '{16'h3C00, 16'h4900, 16'h0000, 16'h0000, 16'h0000};
        ts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ea = '{32'h1000_0A04, 32'h1000_5144, 32'h1000_0020, 32'h1000_09FC};
        eo = '{1'b0, 1'b0, 1'b0, 1'b1};
        base_addr = 32'h1000_0000;
        @(negedge clk);
        ds_rfd = 1'b0;
        fp_x = xs[0]; fp_y = ys[0]; tiled = ts[0]; nd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nd = 1'b0;
        n = 0;
        while (!rdy && n < 10) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || zbuff_addr !== ea[0]) begin
            errors++; $display("FAIL stall_hold got %b/%h want 1/%h", rdy, zbuff_addr, ea[0]);
        end
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            idx = (acc < 3) ? acc + 1 : 4;
            fp_x = xs[idx]; fp_y = ys[idx]; tiled = ts[idx]; nd = 1'b1;
            if (us_rfd) acc++;
            @(negedge clk);
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL stall_accepts got %0d want 3", acc); end
        checks++; if (us_rfd !== 1'b0) begin errors++; $display("FAIL stall_us_rfd got %b want 0", us_rfd); end
        checks++;
        if (rdy !== 1'b1 || zbuff_addr !== ea[0]) begin
            errors++; $display("FAIL stall_still got %b/%h want 1/%h", rdy, zbuff_addr, ea[0]);
        end
        nd = 1'b0; ds_rfd = 1'b1;
        k = 0; first = -1; last = -1;
        for (int c = 0; c < 10; c++) begin
            if (rdy) begin
                if (k < 4) begin
                    checks++;
                    if (zbuff_addr !== ea[k] || oob !== eo[k]) begin
                        errors++;
                        $display("FAIL drain%0d got %h/%b want %h/%b", k, zbuff_addr, oob, ea[k], eo[k]);
                    end
                end
                if (first < 0) first = c;
                last = c;
                k++;
            end
            @(negedge clk);
        end
        checks++; if (k != 4) begin errors++; $display("FAIL drain_count got %0d want 4", k); end
        checks++; if (first != 0 || last != 3) begin
            errors++; $display("FAIL drain_span got %0d..%0d want 0..3", first, last);
        end
    endtask

    task automatic test_reset_flight();
        logic [31:0] a;
        logic o, took;
        int n, seen, lat;
        ds_rfd = 1'b0; base_addr = 32'h1000_0000; tiled = 1'b0;
        @(negedge clk);
        fp_x = 16'h3C00; fp_y = 16'h3C00; nd = 1'b1;
        @(negedge clk);
        fp_x = 16'h4880; fp_y = 16'h4900;
        @(negedge clk);
        nd = 1'b0;
        n = 0;
        while (!rdy && n < 10) begin @(negedge clk); n++; end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rstf_prefill got %b want 1", rdy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstf_rdy got %b want 0", rdy); end
        checks++;
        if (zbuff_addr !== 32'h0 || oob !== 1'b0) begin
            errors++; $display("FAIL rstf_outputs got %h/%b want 00000000/0", zbuff_addr, oob);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; ds_rfd = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstf_stale got %0d want 0", seen); end
        drive_one(16'h4880, 16'h4900, 32'h2000_0000, 1'b1, a, o, lat, took);
        checks++; if (a !== 32'h2000_5144) begin errors++; $display("FAIL rstf_after got %h want 20005144", a); end
        checks++; if (lat != 3) begin errors++; $display("FAIL rstf_latency got %0d want 3", lat); end
    endtask

    initial begin
        rst = 1'b1; nd = 1'b0; ds_rfd = 1'b1; tiled = 1'b0;
        fp_x = '0; fp_y = '0; base_addr = '0;
        #1 rst = 1'b0;
        test_reset();
        test_linear();
        test_tiled();
        test_oob();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
